// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pipe
//  Description : WIDTH-bit adder with carry-in, with the carry chain split into
//                STAGES registered segments of CW = WIDTH/STAGES bits each.
//                Valid/ready on both sides. A stalled output freezes the whole
//                pipe. Bubbles travel down the pipe like data.
//
//  Parameters  : WIDTH  - operand width (sum is WIDTH+1 bits)
//                STAGES - pipeline depth, 1 <= STAGES <= WIDTH, WIDTH%STAGES==0
//
//  Ports       : clk, rst_n (async active-low)
//                in_valid / in_ready   - operand beat handshake
//                a, b, cin             - operands and carry-in
//                out_valid / out_ready - result handshake
//                out_sum               - a + b + cin, MSB is the carry-out
//
//  Build option: ADDER_PIPE_SUB_EN adds input 'sub'. With sub=1 the block
//                computes a - b - cin as a + ~b + (1 - cin); out_sum[WIDTH]=1
//                then means "no borrow". Without the macro the block adds only.
//
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("adder_pipe: STAGES must be in 1..WIDTH and divide WIDTH");
    end

    // Single global advance enable: the pipe moves as one shift register.
    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    logic w_adv;
    assign w_adv    = rst_n && (!out_valid || out_ready);
    assign in_ready = w_adv;

    // ------------------------------------------------------------------------
    // Stage k handles operand chunk k. Its registers hold:
    //   r_vld   - beat valid
    //   r_cy    - carry out of chunk k
    //   r_sum   - result bits 0 .. (k+1)*CW-1
    //   g_fwd   - operand bits not yet consumed (only if any remain)
    // The forwarded operands shrink by CW bits per stage so every stored bit
    // is consumed downstream.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SW  = (k + 1) * CW;
        localparam int REM = WIDTH - SW;

        logic          r_vld;
        logic          r_cy;
        logic [SW-1:0] r_sum;

        logic          w_vld_in;
        logic          w_cy_in;
        logic [CW-1:0] w_a_chunk;
        logic [CW-1:0] w_b_chunk;
        logic [CW-1:0] w_b_eff;
        logic [CW:0]   w_add;
        logic [SW-1:0] w_sum_nxt;
`ifdef ADDER_PIPE_SUB_EN
        logic          w_sub_in;
`endif

        if (k == 0) begin : g_src
            assign w_vld_in  = in_valid;
            assign w_a_chunk = a[CW-1:0];
            assign w_b_chunk = b[CW-1:0];
`ifdef ADDER_PIPE_SUB_EN
            assign w_sub_in  = sub;
            // Subtract: carry-in of the chain is (1 - cin).
            assign w_cy_in   = cin ^ sub;
`else
            assign w_cy_in   = cin;
`endif
            assign w_sum_nxt = w_add[CW-1:0];
        end else begin : g_src
            assign w_vld_in  = g_stage[k-1].r_vld;
            assign w_cy_in   = g_stage[k-1].r_cy;
            assign w_a_chunk = g_stage[k-1].g_fwd.r_a_rem[CW-1:0];
            assign w_b_chunk = g_stage[k-1].g_fwd.r_b_rem[CW-1:0];
`ifdef ADDER_PIPE_SUB_EN
            assign w_sub_in  = g_stage[k-1].g_fwd.r_sub;
`endif
            assign w_sum_nxt = {w_add[CW-1:0], g_stage[k-1].r_sum};
        end

`ifdef ADDER_PIPE_SUB_EN
        assign w_b_eff = w_b_chunk ^ {CW{w_sub_in}};
`else
        assign w_b_eff = w_b_chunk;
`endif

        // The one CW-bit adder of this stage.
        assign w_add = {1'b0, w_a_chunk} + {1'b0, w_b_eff} + {{CW{1'b0}}, w_cy_in};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_cy  <= 1'b0;
                r_sum <= '0;
            end else if (w_adv) begin
                r_vld <= w_vld_in;
                r_cy  <= w_add[CW];
                r_sum <= w_sum_nxt;
            end
        end

        if (REM > 0) begin : g_fwd
            logic [REM-1:0] r_a_rem;
            logic [REM-1:0] r_b_rem;
            logic [REM-1:0] w_a_rem_in;
            logic [REM-1:0] w_b_rem_in;
`ifdef ADDER_PIPE_SUB_EN
            logic           r_sub;
`endif

            if (k == 0) begin : g_rem_src
                assign w_a_rem_in = a[WIDTH-1:CW];
                assign w_b_rem_in = b[WIDTH-1:CW];
            end else begin : g_rem_src
                assign w_a_rem_in = g_stage[k-1].g_fwd.r_a_rem[REM+CW-1:CW];
                assign w_b_rem_in = g_stage[k-1].g_fwd.r_b_rem[REM+CW-1:CW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_rem <= '0;
                    r_b_rem <= '0;
`ifdef ADDER_PIPE_SUB_EN
                    r_sub   <= 1'b0;
`endif
                end else if (w_adv) begin
                    r_a_rem <= w_a_rem_in;
                    r_b_rem <= w_b_rem_in;
`ifdef ADDER_PIPE_SUB_EN
                    r_sub   <= w_sub_in;
`endif
                end
            end
        end
    end

    assign out_valid = g_stage[LAST].r_vld;
    assign out_sum   = {g_stage[LAST].r_cy, g_stage[LAST].r_sum};

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_pipe
//  Description : Directed self-checking bench for adder_pipe. Main instance is
//                WIDTH=8/STAGES=2; three extra instances (8/1, 8/8, 32/4)
//                cover the parameter sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Main DUT
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] out_sum;
`ifdef ADDER_PIPE_SUB_EN
    logic       sub = 1'b0;
`endif

    adder_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDER_PIPE_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    // Sweep instances share stimulus
    logic        sw_in_valid = 1'b0;
    logic        sw_out_ready = 1'b1;
    logic [31:0] sw_a = '0;
    logic [31:0] sw_b = '0;
    logic        sw_cin = 1'b0;

    logic        s1_in_ready, s1_out_valid;
    logic [8:0]  s1_out_sum;
    logic        s8_in_ready, s8_out_valid;
    logic [8:0]  s8_out_sum;
    logic        s32_in_ready, s32_out_valid;
    logic [32:0] s32_out_sum;

    adder_pipe #(.WIDTH(8), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(s1_in_ready),
        .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin),
`ifdef ADDER_PIPE_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(s1_out_valid), .out_ready(sw_out_ready), .out_sum(s1_out_sum)
    );

    adder_pipe #(.WIDTH(8), .STAGES(8)) dut_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(s8_in_ready),
        .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin),
`ifdef ADDER_PIPE_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(s8_out_valid), .out_ready(sw_out_ready), .out_sum(s8_out_sum)
    );

    adder_pipe #(.WIDTH(32), .STAGES(4)) dut_s32 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(s32_in_ready),
        .a(sw_a), .b(sw_b), .cin(sw_cin),
`ifdef ADDER_PIPE_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(s32_out_valid), .out_ready(sw_out_ready), .out_sum(s32_out_sum)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_sum !== 9'h000) begin n_err++; $display("FAIL reset_out_sum: got %h want 000", out_sum); end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++;
        if (s32_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_s32_out_valid: got %b want 0", s32_out_valid); end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_basic();
        out_ready = 1'b1;
        a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency_valid: got %b want 1", out_valid); end
        n_cmp++;
        if (out_sum !== 9'h1FF) begin n_err++; $display("FAIL basic_sum: got %h want 1ff", out_sum); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop: got %b want 0", out_valid); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        int got;
        logic [8:0] exp;
        got = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = 8'(i); b = 8'(2 * i); cin = i[0]; in_valid = 1'b1;
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready beat %0d: got %b want 1", i, in_ready); end
            if (out_valid === 1'b1) begin
                exp = 9'(3 * got + (got % 2));
                n_cmp++;
                if (out_sum !== exp) begin n_err++; $display("FAIL stream_sum result %0d: got %h want %h", got, out_sum, exp); end
                got++;
            end
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 8 && got < 16; c++) begin
            #1;
            if (out_valid === 1'b1) begin
                exp = 9'(3 * got + (got % 2));
                n_cmp++;
                if (out_sum !== exp) begin n_err++; $display("FAIL stream_sum result %0d: got %h want %h", got, out_sum, exp); end
                got++;
            end
            tick();
        end
        n_cmp++;
        if (got != 16) begin n_err++; $display("FAIL stream_count: got %0d want 16", got); end
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_extra_beat: got %b want 0", out_valid); end
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_backpressure();
        out_ready = 1'b0;
        a = 8'h10; b = 8'h20; cin = 1'b0; in_valid = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tick();
        // Second beat waits at the input while the output is stalled.
        a = 8'h01; b = 8'h02; cin = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid cyc %0d: got %b want 1", c, out_valid); end
            n_cmp++;
            if (out_sum !== 9'h030) begin n_err++; $display("FAIL bp_hold_sum cyc %0d: got %h want 030", c, out_sum); end
            n_cmp++;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_in_ready cyc %0d: got %b want 0", c, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_bubble: got %b want 0", out_valid); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
        n_cmp++;
        if (out_sum !== 9'h004) begin n_err++; $display("FAIL bp_next_sum: got %h want 004", out_sum); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid();
        out_ready = 1'b1;
        a = 8'h33; b = 8'h44; cin = 1'b0; in_valid = 1'b1;
        tick();
        a = 8'h01; b = 8'h01; cin = 1'b0;
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid: got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_sum !== 9'h000) begin n_err++; $display("FAIL midrst_sum: got %h want 000", out_sum); end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        tick();
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_ghost cyc %0d: got %b want 0", c, out_valid); end
            tick();
        end
        a = 8'h02; b = 8'h03; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_sum !== 9'h006) begin
            n_err++; $display("FAIL midrst_new_beat: got valid=%b sum=%h want valid=1 sum=006", out_valid, out_sum);
        end
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_sweep_latency();
        int lat1, lat8, lat32;
        logic [8:0]  sum1, sum8;
        logic [32:0] sum32;
        lat1 = 0; lat8 = 0; lat32 = 0;
        sum1 = '0; sum8 = '0; sum32 = '0;
        sw_out_ready = 1'b1;
        sw_a = 32'h89AB_CDEF; sw_b = 32'h1234_5678; sw_cin = 1'b1; sw_in_valid = 1'b1;
        #1;
        n_cmp++;
        if ({s1_in_ready, s8_in_ready, s32_in_ready} !== 3'b111) begin
            n_err++; $display("FAIL sweep_in_ready: got %b want 111", {s1_in_ready, s8_in_ready, s32_in_ready});
        end
        tick();
        sw_in_valid = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (s1_out_valid === 1'b1 && lat1 == 0)   begin lat1 = cyc;  sum1 = s1_out_sum;   end
            if (s8_out_valid === 1'b1 && lat8 == 0)   begin lat8 = cyc;  sum8 = s8_out_sum;   end
            if (s32_out_valid === 1'b1 && lat32 == 0) begin lat32 = cyc; sum32 = s32_out_sum; end
            tick();
        end
        n_cmp++;
        if (lat1 != 1) begin n_err++; $display("FAIL sweep_lat_s1: got %0d want 1", lat1); end
        n_cmp++;
        if (lat8 != 8) begin n_err++; $display("FAIL sweep_lat_s8: got %0d want 8", lat8); end
        n_cmp++;
        if (lat32 != 4) begin n_err++; $display("FAIL sweep_lat_w32: got %0d want 4", lat32); end
        n_cmp++;
        if (sum1 !== 9'h168) begin n_err++; $display("FAIL sweep_sum_s1: got %h want 168", sum1); end
        n_cmp++;
        if (sum8 !== 9'h168) begin n_err++; $display("FAIL sweep_sum_s8: got %h want 168", sum8); end
        n_cmp++;
        if (sum32 !== 33'h0_9BE0_2468) begin n_err++; $display("FAIL sweep_sum_w32: got %h want 09be02468", sum32); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_sweep_stream();
        logic [8:0]  q1[$];
        logic [8:0]  q8[$];
        logic [32:0] q32[$];
        logic [8:0]  e8;
        logic [32:0] e32;
        int outs;
        outs = 0;
        for (int c = 0; c < 70; c++) begin
            sw_in_valid  = (c < 40);
            sw_out_ready = (c < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
            sw_a = $urandom; sw_b = $urandom; sw_cin = 1'($urandom_range(0, 1));
            #1;
            if (s1_out_valid === 1'b1 && sw_out_ready) begin
                e8 = (q1.size() > 0) ? q1.pop_front() : 9'hxxx;
                n_cmp++; outs++;
                if (s1_out_sum !== e8) begin n_err++; $display("FAIL sweep_s1_sum: got %h want %h", s1_out_sum, e8); end
            end
            if (s8_out_valid === 1'b1 && sw_out_ready) begin
                e8 = (q8.size() > 0) ? q8.pop_front() : 9'hxxx;
                n_cmp++; outs++;
                if (s8_out_sum !== e8) begin n_err++; $display("FAIL sweep_s8_sum: got %h want %h", s8_out_sum, e8); end
            end
            if (s32_out_valid === 1'b1 && sw_out_ready) begin
                e32 = (q32.size() > 0) ? q32.pop_front() : 33'hx;
                n_cmp++; outs++;
                if (s32_out_sum !== e32) begin n_err++; $display("FAIL sweep_w32_sum: got %h want %h", s32_out_sum, e32); end
            end
            e8  = {1'b0, sw_a[7:0]} + {1'b0, sw_b[7:0]} + {8'd0, sw_cin};
            e32 = {1'b0, sw_a} + {1'b0, sw_b} + {32'd0, sw_cin};
            if (sw_in_valid && s1_in_ready)  q1.push_back(e8);
            if (sw_in_valid && s8_in_ready)  q8.push_back(e8);
            if (sw_in_valid && s32_in_ready) q32.push_back(e32);
            tick();
        end
        sw_in_valid = 1'b0;
        n_cmp++;
        if (q1.size() + q8.size() + q32.size() != 0) begin
            n_err++; $display("FAIL sweep_leftover: got %0d/%0d/%0d want 0/0/0", q1.size(), q8.size(), q32.size());
        end
        n_cmp++;
        if (outs == 0) begin n_err++; $display("FAIL sweep_no_output: got 0 results want >0"); end
    endtask

`ifdef ADDER_PIPE_SUB_EN
    task automatic test_sub();
        logic [7:0] va[3]   = '{8'd5, 8'd7, 8'd7};
        logic [7:0] vb[3]   = '{8'd7, 8'd5, 8'd5};
        logic       vc[3]   = '{1'b0, 1'b0, 1'b1};
        logic [8:0] vexp[3] = '{9'h0FE, 9'h102, 9'h101};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = va[i]; b = vb[i]; cin = vc[i]; sub = 1'b1; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_sum !== vexp[i]) begin
                n_err++; $display("FAIL sub_vec%0d: got valid=%b sum=%h want valid=1 sum=%h", i, out_valid, out_sum, vexp[i]);
            end
            tick();
        end
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_sweep_latency();
        test_sweep_stream();
`ifdef ADDER_PIPE_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
